decode_family_stage: RTL

//  Registered ARMv4 decode-family stage with valid/ready handshake and DEPTH-entry output queue.

---
 rtl/decode_family_stage.sv | 111 +++++++++++
 1 files changed

// File: rtl/decode_family_stage.sv
// ARMv4 decode-family classifier feeding a DEPTH-entry queue. Accepted words appear on out_* one cycle later.
// in_ready falls when the queue is full or flush is high; a full queue does not pass a word straight through.
module decode_family_stage #(
  parameter int DEPTH        = 4,
  parameter int CNT_WIDTH    = 16,
  parameter bit COPROC_UNDEF = 1'b0,
  parameter bit NV_UNDEF     = 1'b1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 flush,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [31:0]          in_ir,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [31:0]          out_ir,
  output logic [16:0]          out_family,
  output logic [CNT_WIDTH-1:0] undef_count
);

  localparam int AW = $clog2(DEPTH);

  logic [AW-1:0] rd_ptr, wr_ptr;
  logic [AW:0]   count;
  logic [31:0]   mem_ir  [DEPTH];
  logic [16:0]   mem_fam [DEPTH];
  logic [16:0]   fam;
  logic          push, pop;

  always_comb begin
    fam = '0;
    case (in_ir[27:25])
      3'b001: begin
        if (in_ir[24:23] == 2'b10 && in_ir[21:20] == 2'b10)      fam[6]  = 1'b1;
        else if (in_ir[24:23] == 2'b10 && in_ir[21:20] == 2'b00) fam[16] = 1'b1;
        else                                                     fam[0]  = 1'b1;
      end
      3'b010: fam[9] = 1'b1;
      3'b011: begin
        if (!in_ir[4]) fam[10] = 1'b1;
        else           fam[16] = 1'b1;
      end
      3'b100: fam[14] = 1'b1;
      3'b101: fam[15] = 1'b1;
      3'b110, 3'b111: fam[16] = COPROC_UNDEF;
      default: begin
        // The 000 space is ambiguous; the checks below are ordered by priority.
        if (in_ir[7:4] == 4'b1001) begin
          if (in_ir[24:22] == 3'b000)                                fam[3]  = 1'b1;
          else if (in_ir[24:23] == 2'b01)                            fam[4]  = 1'b1;
          else if (in_ir[24:23] == 2'b10 && in_ir[21:20] == 2'b00)   fam[13] = 1'b1;
          else                                                       fam[16] = 1'b1;
        end else if (in_ir[7] && in_ir[4]) begin
          if (in_ir[22]) fam[11] = 1'b1;
          else           fam[12] = 1'b1;
        end else if (in_ir[24:23] == 2'b10 && !in_ir[20]) begin
          if (in_ir[7:4] == 4'b0001 && in_ir[22:21] == 2'b01)        fam[8]  = 1'b1;
          else if (in_ir[7:4] == 4'b0000 && !in_ir[21])              fam[5]  = 1'b1;
          else if (in_ir[7:4] == 4'b0000 && in_ir[21])               fam[7]  = 1'b1;
          else                                                       fam[16] = 1'b1;
        end else if (!in_ir[4]) begin
          fam[1] = 1'b1;
        end else begin
          fam[2] = 1'b1;
        end
      end
    endcase
    if (NV_UNDEF && in_ir[31:28] == 4'hF) fam = 17'h10000;
  end

  assign in_ready   = (count < (AW+1)'(DEPTH)) && !flush;
  assign out_valid  = (count != '0);
  assign push       = in_valid && in_ready;
  assign pop        = out_valid && out_ready && !flush;
  assign out_ir     = out_valid ? mem_ir[rd_ptr]  : '0;
  assign out_family = out_valid ? mem_fam[rd_ptr] : '0;

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_ptr      <= '0;
      wr_ptr      <= '0;
      count       <= '0;
      undef_count <= '0;
    end else begin
      if (flush) begin
        rd_ptr <= '0;
        wr_ptr <= '0;
        count  <= '0;
      end else begin
        if (push) wr_ptr <= wr_ptr + 1'b1;
        if (pop)  rd_ptr <= rd_ptr + 1'b1;
        case ({push, pop})
          2'b10:   count <= count + 1'b1;
          2'b01:   count <= count - 1'b1;
          default: count <= count;
        endcase
      end
      if (push && fam[16] && !(&undef_count)) undef_count <= undef_count + 1'b1;
    end
  end

  // Storage needs no reset: out_* are gated by count.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_ir[wr_ptr]  <= in_ir;
      mem_fam[wr_ptr] <= fam;
    end
  end

endmodule
